reg_bank_uart_rw: RTL and testbench
===================================

// Module: reg_bank_uart_rw
// PURPOSE
//  Generalised UART-configured register bank for the GPS signal generator.
//  Holds NUM_REGS 8-bit write/read registers loaded over a serial command stream.
//  Decodes two-byte write commands and one-byte read commands from an internal uart_rx.
//  Read replies go out on a valid/ready byte interface to an external uart_tx.
//  Sits between the host serial link and the signal-generation core (enable, sat ID, doppler, CA phase, SNR).
// PARAMETERS
//  CLKS_PER_BIT  142             clk_in cycles per UART bit, passed to uart_rx (16.368 MHz / 115200).
//  NUM_REGS      8               number of 8-bit registers; legal range 2..128.
//  RESET_VALS    64'h0000_0000_0000_C000  NUM_REGS*8-bit reset image; reg i = RESET_VALS[8i+7:8i]. Must be overridden when NUM_REGS != 8.
//  TIMEOUT_CLKS  5680            idle cycles allowed between command and data byte (4 byte times).
// PORTS
//  clk_in         in   1            system clock.
//  rst_in_n       in   1            reset, asynchronous, active-low.
//  rx_in          in   1            UART serial input, 8N1.
//  regs_out       out  NUM_REGS*8   flat register image; reg i on [8i+7:8i].
//  wr_strobe_out  out  NUM_REGS     one-hot, 1-cycle pulse: reg i was just updated.
//  tx_data_out    out  8            read-reply byte.
//  tx_valid_out   out  1            tx_data_out valid; held until accepted.
//  tx_ready_in    in   1            downstream uart_tx accepts byte when high with tx_valid_out.
//  err_out        out  1            1-cycle pulse on protocol error.
// BEHAVIOUR
//  Reset: regs_out=RESET_VALS, wr_strobe_out=0, tx_valid_out=0, tx_data_out=0, err_out=0, FSM=IDLE. Applies mid-operation; pending reply dropped.
//  Command byte: bit7 = 1 read / 0 write; bits[6:0] = address. Write data byte follows the command byte.
//  ADDR_W = clog2(NUM_REGS), fixed at elaboration. An address is out of range when addr >= NUM_REGS.
//  FSM states: IDLE, GET_DATA, SEND.
//   IDLE: rx_dv pulse latches the command byte.
//    - Write command: go to GET_DATA.
//    - Read command, in-range address: go to SEND.
//    - Read command, out-of-range address: err_out pulse, remain in IDLE.
//   GET_DATA: the timeout counter runs from 0.
//    - rx_dv, in-range address: reg[addr] <= rx_data on that edge.
//      wr_strobe_out[addr] high for the following cycle only. Go to IDLE.
//    - rx_dv, out-of-range address: byte discarded, err_out pulse, go to IDLE.
//    - Counter reaches TIMEOUT_CLKS-1 without rx_dv: err_out pulse, go to IDLE; the next byte is a command.
//    - rx_dv in the same cycle as the timeout: the byte is accepted; no error.
//   SEND: tx_valid_out=1 the cycle after entry; tx_data_out = reg[addr] sampled on entry.
//    - tx_data_out stays stable while waiting for ready.
//    - tx_valid_out && tx_ready_in: go to IDLE; tx_valid_out=0 next cycle.
//    - No timeout in SEND.
//    - An rx byte arriving in SEND is dropped with an err_out pulse.
//  Latency: register update one edge after the data byte's rx_dv. Read reply valid 2 cycles after the command's rx_dv.
//  Only the GET_DATA commit path writes registers; at most one register changes per cycle.
// CONFIGURATION
//  REG_BANK_READBACK_EN defined:
//   - Read commands are served through the SEND state as above.
//  REG_BANK_READBACK_EN undefined:
//   - SEND state and tx logic are removed; tx_valid_out=0 and tx_data_out=0 constantly; tx_ready_in is ignored.
//   - Any read command gives an err_out pulse and the FSM stays in IDLE.
// TESTING
//  Write: send 0x03, then 0x5A -> regs_out[31:24]=0x5A, wr_strobe_out=8'h08 for exactly 1 cycle, err_out never high.
//  Read with backpressure: after the write above, send 0x83; hold tx_ready_in low for 10 cycles.
//   -> tx_valid_out=1 and tx_data_out=0x5A, stable throughout; after the ready cycle tx_valid_out=0.
//  Out of range: send 0x7F, then 0x11 -> one err_out pulse, regs_out unchanged, wr_strobe_out stays 0.
//  Timeout: send 0x02, then wait TIMEOUT_CLKS idle cycles -> err_out pulse.
//   -> Then send 0x04, 0xAA: reg4=0xAA and reg2 unchanged.
//  Reset mid-read: assert rst_in_n low while tx_valid_out=1.
//   -> tx_valid_out=0 immediately (asynchronous); regs_out=RESET_VALS (reg1=0xC0).
//  Macro off: send 0x81 -> err_out pulse, tx_valid_out stays 0, FSM back in IDLE.
//   -> A following 0x01, 0x22 writes reg1=0x22.

Source files
------------

// File: rtl/reg_bank_uart_rw.sv
// UART-configured register bank: 2-byte write commands, 1-byte read commands, byte-wide read replies.
// Build option: define REG_BANK_READBACK_EN to enable read replies (SEND state and tx path).

module reg_bank_uart_rx #(
  parameter int CLKS_PER_BIT = 142
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       rx_in,
  output logic       rx_dv,
  output logic [7:0] rx_data
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t        state_q;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       data_q;
  logic             rx_s;

  assign rx_s    = sync_q[1];
  assign rx_data = data_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly as the hardware does.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      sync_q    <= 2'b11;
      state_q   <= R_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      rx_dv     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_in};
      rx_dv  <= 1'b0;
      case (state_q)
        R_IDLE: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (!rx_s) state_q <= R_START;
        end
        R_START: begin
          // Re-check the line at mid start bit to reject glitches.
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= rx_s ? R_IDLE : R_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            data_q    <= {rx_s, data_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= R_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            rx_dv     <= rx_s;
            state_q   <= R_IDLE;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

endmodule

module reg_bank_uart_rw #(
  parameter int                    CLKS_PER_BIT = 142,
  parameter int                    NUM_REGS     = 8,
  parameter logic [NUM_REGS*8-1:0] RESET_VALS   = 64'h0000_0000_0000_C000,
  parameter int                    TIMEOUT_CLKS = 5680
) (
  input  logic                  clk_in,
  input  logic                  rst_in_n,
  input  logic                  rx_in,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic [NUM_REGS-1:0]   wr_strobe_out,
  output logic [7:0]            tx_data_out,
  output logic                  tx_valid_out,
  input  logic                  tx_ready_in,
  output logic                  err_out
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int TO_W   = $clog2(TIMEOUT_CLKS);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]      NUM_REGS_B = 8'(NUM_REGS);

`ifdef REG_BANK_READBACK_EN
  typedef enum logic [1:0] {S_IDLE, S_GET_DATA, S_SEND} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_GET_DATA} state_t;
`endif

  state_t              state_q;
  logic [6:0]          cmd_addr_q;
  logic [ADDR_W-1:0]   cmd_idx;
  logic [TO_W-1:0]     to_cnt_q;
  logic [7:0]          regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_strobe_q;
  logic                err_q;
  logic                tx_valid_q;
  logic [7:0]          tx_data_q;
  logic                rx_dv;
  logic [7:0]          rx_data;

  reg_bank_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_in  (clk_in),
    .rst_in_n(rst_in_n),
    .rx_in   (rx_in),
    .rx_dv   (rx_dv),
    .rx_data (rx_data)
  );

  function automatic logic in_range(input logic [6:0] addr);
    return {1'b0, addr} < NUM_REGS_B;
  endfunction

  assign cmd_idx = cmd_addr_q[ADDR_W-1:0];

  // NOTE: the bank is built from flops, not RAM, so every entry takes its
  // reset image on rst_in_n; downstream logic relies on those defaults.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q     <= S_IDLE;
      cmd_addr_q  <= '0;
      to_cnt_q    <= '0;
      wr_strobe_q <= '0;
      err_q       <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALS[8*i +: 8];
    end else begin
      wr_strobe_q <= '0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_dv) begin
            cmd_addr_q <= rx_data[6:0];
            to_cnt_q   <= '0;
            if (!rx_data[7]) begin
              state_q <= S_GET_DATA;
`ifdef REG_BANK_READBACK_EN
            end else if (in_range(rx_data[6:0])) begin
              state_q <= S_SEND;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_GET_DATA: begin
          // A data byte landing on the timeout cycle wins over the timeout.
          if (rx_dv) begin
            state_q <= S_IDLE;
            if (in_range(cmd_addr_q)) begin
              regs_q[cmd_idx]      <= rx_data;
              wr_strobe_q[cmd_idx] <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (to_cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
`ifdef REG_BANK_READBACK_EN
        S_SEND: begin
          if (rx_dv) err_q <= 1'b1;
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= regs_q[cmd_idx];
          end else if (tx_ready_in) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[8*g +: 8] = regs_q[g];
  end

  assign wr_strobe_out = wr_strobe_q;
  assign err_out       = err_q;

`ifdef REG_BANK_READBACK_EN
  assign tx_valid_out = tx_valid_q;
  assign tx_data_out  = tx_data_q;
`else
  logic unused_tx;
  assign unused_tx    = tx_ready_in ^ tx_valid_q ^ (^tx_data_q);
  assign tx_valid_out = 1'b0;
  assign tx_data_out  = '0;
`endif

endmodule

// File: tb/tb_reg_bank_uart_rw.sv
// Directed bench for reg_bank_uart_rw; covers both builds of REG_BANK_READBACK_EN.

module tb_reg_bank_uart_rw;

  localparam int CPB      = 16;
  localparam int TIMEOUT  = 640;
  localparam logic [63:0] RST_IMG = 64'h0000_0000_0000_C000;

  logic        clk_in = 1'b0;
  logic        rst_in_n = 1'b0;
  logic        rx_in = 1'b1;
  logic [63:0] regs_out;
  logic [7:0]  wr_strobe_out;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in = 1'b0;
  logic        err_out;

  int n_cmp = 0;
  int n_bad = 0;

  int          err_cnt = 0;
  int          strobe_cnt = 0;
  int          valid_cnt = 0;
  logic [7:0]  strobe_last = '0;
  logic [63:0] exp_regs = RST_IMG;

  always #5 clk_in = ~clk_in;

  reg_bank_uart_rw #(
    .CLKS_PER_BIT(CPB),
    .NUM_REGS    (8),
    .RESET_VALS  (RST_IMG),
    .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .clk_in       (clk_in),
    .rst_in_n     (rst_in_n),
    .rx_in        (rx_in),
    .regs_out     (regs_out),
    .wr_strobe_out(wr_strobe_out),
    .tx_data_out  (tx_data_out),
    .tx_valid_out (tx_valid_out),
    .tx_ready_in  (tx_ready_in),
    .err_out      (err_out)
  );

  always @(negedge clk_in) begin
    if (err_out) err_cnt++;
    if (wr_strobe_out != 8'h00) begin
      strobe_cnt++;
      strobe_last = wr_strobe_out;
    end
    if (tx_valid_out) valid_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk_in);
    end
    rx_in = 1'b1;
    repeat (CPB) @(negedge clk_in);
  endtask

  task automatic write_reg(input logic [7:0] cmd, input logic [7:0] data);
    send_byte(cmd);
    send_byte(data);
    repeat (4) @(negedge clk_in);
  endtask

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_in);
    cmp("reset regs", regs_out, RST_IMG);
    cmp("reset strobe", {56'd0, wr_strobe_out}, 64'd0);
    cmp("reset tx_valid", {63'd0, tx_valid_out}, 64'd0);
    cmp("reset tx_data", {56'd0, tx_data_out}, 64'd0);
    cmp("reset err", {63'd0, err_out}, 64'd0);
    rst_in_n = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic test_write;
    int e0, s0;
    e0 = err_cnt; s0 = strobe_cnt;
    write_reg(8'h03, 8'h5A);
    exp_regs[31:24] = 8'h5A;
    cmp("write regs", regs_out, exp_regs);
    cmp("write strobe cycles", 64'(strobe_cnt - s0), 64'd1);
    cmp("write strobe value", {56'd0, strobe_last}, 64'h08);
    cmp("write no err", 64'(err_cnt - e0), 64'd0);
  endtask

`ifdef REG_BANK_READBACK_EN
  task automatic test_read_backpressure;
    int e0, waited, unstable;
    e0 = err_cnt; waited = 0; unstable = 0;
    tx_ready_in = 1'b0;
    send_byte(8'h83);
    while (!tx_valid_out && waited < 400) begin
      @(negedge clk_in);
      waited++;
    end
    cmp("read valid seen", {63'd0, tx_valid_out}, 64'd1);
    cmp("read data", {56'd0, tx_data_out}, 64'h5A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (tx_valid_out !== 1'b1 || tx_data_out !== 8'h5A) unstable++;
    end
    cmp("read stable under backpressure", 64'(unstable), 64'd0);
    tx_ready_in = 1'b1;
    @(negedge clk_in);
    tx_ready_in = 1'b0;
    cmp("read valid drops after accept", {63'd0, tx_valid_out}, 64'd0);
    cmp("read no err", 64'(err_cnt - e0), 64'd0);
  endtask
`endif

  task automatic test_out_of_range;
    int e0, s0;
    e0 = err_cnt; s0 = strobe_cnt;
    write_reg(8'h7F, 8'h11);
    cmp("oor 0x7F err", 64'(err_cnt - e0), 64'd1);
    cmp("oor 0x7F regs", regs_out, exp_regs);
    e0 = err_cnt;
    write_reg(8'h08, 8'h11);
    cmp("oor 0x08 err", 64'(err_cnt - e0), 64'd1);
    cmp("oor regs", regs_out, exp_regs);
    cmp("oor no strobe", 64'(strobe_cnt - s0), 64'd0);
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_cnt;
    send_byte(8'h02);
    repeat (TIMEOUT + 60) @(negedge clk_in);
    cmp("timeout err", 64'(err_cnt - e0), 64'd1);
    write_reg(8'h04, 8'hAA);
    exp_regs[39:32] = 8'hAA;
    cmp("after timeout regs", regs_out, exp_regs);
    cmp("after timeout single err", 64'(err_cnt - e0), 64'd1);
  endtask

  task automatic test_slow_data;
    int e0;
    e0 = err_cnt;
    send_byte(8'h05);
    repeat (300) @(negedge clk_in);
    send_byte(8'h33);
    repeat (4) @(negedge clk_in);
    exp_regs[47:40] = 8'h33;
    cmp("slow data regs", regs_out, exp_regs);
    cmp("slow data no err", 64'(err_cnt - e0), 64'd0);
  endtask

  task automatic test_back_to_back;
    int s0;
    s0 = strobe_cnt;
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h07);
    send_byte(8'h77);
    repeat (4) @(negedge clk_in);
    exp_regs[7:0]   = 8'h11;
    exp_regs[63:56] = 8'h77;
    cmp("b2b regs", regs_out, exp_regs);
    cmp("b2b strobes", 64'(strobe_cnt - s0), 64'd2);
    cmp("b2b last strobe", {56'd0, strobe_last}, 64'h80);
  endtask

  task automatic test_read_cmd;
    int e0, v0;
    e0 = err_cnt; v0 = valid_cnt;
`ifdef REG_BANK_READBACK_EN
    send_byte(8'h88);
    repeat (6) @(negedge clk_in);
    cmp("oor read err", 64'(err_cnt - e0), 64'd1);
    cmp("oor read no reply", 64'(valid_cnt - v0), 64'd0);
`else
    send_byte(8'h81);
    repeat (6) @(negedge clk_in);
    cmp("macro off read err", 64'(err_cnt - e0), 64'd1);
    cmp("macro off no valid", 64'(valid_cnt - v0), 64'd0);
    cmp("macro off tx_data", {56'd0, tx_data_out}, 64'd0);
`endif
    write_reg(8'h01, 8'h22);
    exp_regs[15:8] = 8'h22;
    cmp("write after read regs", regs_out, exp_regs);
    cmp("write after read single err", 64'(err_cnt - e0), 64'd1);
  endtask

  task automatic test_reset_mid_op;
`ifdef REG_BANK_READBACK_EN
    int waited;
    waited = 0;
    tx_ready_in = 1'b0;
    send_byte(8'h81);
    while (!tx_valid_out && waited < 400) begin
      @(negedge clk_in);
      waited++;
    end
    cmp("mid-read valid before reset", {63'd0, tx_valid_out}, 64'd1);
    #2 rst_in_n = 1'b0;
    #1;
    cmp("mid-read valid async drop", {63'd0, tx_valid_out}, 64'd0);
    cmp("mid-read regs reset", regs_out, RST_IMG);
    @(negedge clk_in);
    rst_in_n = 1'b1;
    repeat (4) @(negedge clk_in);
`endif
    send_byte(8'h06);
    #2 rst_in_n = 1'b0;
    #1;
    cmp("mid-write regs reset", regs_out, RST_IMG);
    @(negedge clk_in);
    rst_in_n = 1'b1;
    repeat (4) @(negedge clk_in);
    exp_regs = RST_IMG;
    write_reg(8'h06, 8'h66);
    exp_regs[55:48] = 8'h66;
    cmp("post-reset write regs", regs_out, exp_regs);
  endtask

  initial begin
    test_reset();
    test_write();
`ifdef REG_BANK_READBACK_EN
    test_read_backpressure();
`endif
    test_out_of_range();
    test_timeout();
    test_slow_data();
    test_back_to_back();
    test_read_cmd();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
